// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 1/2/5 zl coin payout controller with inventory tracking
`timescale 1ns/1ps
module change_dispenser #(
  parameter int AMT_W     = 8,
  parameter int CNT_W     = 6,
  parameter int INIT_CNT  = 20,
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic [2:0]       eject,
  input  logic             coin_sensed,
  input  logic             refill,
  input  logic [2:0]       refill_sel,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] dispensed_total,
  output logic [CNT_W-1:0] inv1,
  output logic [CNT_W-1:0] inv2,
  output logic [CNT_W-1:0] inv5
);

  localparam int TMR_MAX = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_INIT     = CNT_W'(INIT_CNT);
  localparam logic [AMT_W-1:0] VAL1         = AMT_W'(1);
  localparam logic [AMT_W-1:0] VAL2         = AMT_W'(2);
  localparam logic [AMT_W-1:0] VAL5         = AMT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_WAIT_SENSE, S_DONE, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] inv1_q, inv1_d, inv2_q, inv2_d, inv5_q, inv5_d;
  logic [2:0]       sel_q, sel_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       err_q, err_d;
  logic [AMT_W-1:0] sel_val;

  always_comb begin
    sel_val = VAL1;
    if (sel_q[2])      sel_val = VAL5;
    else if (sel_q[1]) sel_val = VAL2;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    inv1_d      = inv1_q;
    inv2_d      = inv2_q;
    inv5_d      = inv5_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        // Malformed (non-one-hot) refill selects fall through and are dropped.
        if (refill) begin
          case (refill_sel)
            3'b001:  if (inv1_q != CNT_MAX) inv1_d = inv1_q + 1'b1;
            3'b010:  if (inv2_q != CNT_MAX) inv2_d = inv2_q + 1'b1;
            3'b100:  if (inv5_q != CNT_MAX) inv5_d = inv5_q + 1'b1;
            default: ;
          endcase
        end
        if (req_valid) begin
          remaining_d = req_amount;
          total_d     = '0;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        timer_d = '0;
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (remaining_q >= VAL5 && inv5_q != '0) begin
          sel_d   = 3'b100;
          state_d = S_EJECT;
        end else if (remaining_q >= VAL2 && inv2_q != '0) begin
          sel_d   = 3'b010;
          state_d = S_EJECT;
        end else if (inv1_q != '0) begin
          sel_d   = 3'b001;
          state_d = S_EJECT;
        end else begin
          err_d   = 2'b01;
          state_d = S_FAULT;
        end
      end
      S_EJECT: begin
        if (timer_q == PULSE_LAST) begin
          timer_d = '0;
          state_d = S_WAIT_SENSE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_SENSE: begin
        // A sense arriving on the final timeout cycle still counts as a paid coin.
        if (coin_sensed) begin
          remaining_d = remaining_q - sel_val;
          total_d     = total_q + sel_val;
          if (sel_q[2] && inv5_q != '0)      inv5_d = inv5_q - 1'b1;
          else if (sel_q[1] && inv2_q != '0) inv2_d = inv2_q - 1'b1;
          else if (sel_q[0] && inv1_q != '0) inv1_d = inv1_q - 1'b1;
          state_d = S_SELECT;
        end else if (timer_q == TIMEOUT_LAST) begin
          err_d   = 2'b10;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (clear) begin
          err_d   = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      total_q     <= '0;
      inv1_q      <= CNT_INIT;
      inv2_q      <= CNT_INIT;
      inv5_q      <= CNT_INIT;
      sel_q       <= 3'b001;
      timer_q     <= '0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      inv1_q      <= inv1_d;
      inv2_q      <= inv2_d;
      inv5_q      <= inv5_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign error           = (state_q == S_FAULT);
  assign eject           = (state_q == S_EJECT) ? sel_q : 3'b000;
  assign err_code        = err_q;
  assign remaining       = remaining_q;
  assign dispensed_total = total_q;
  assign inv1            = inv1_q;
  assign inv2            = inv2_q;
  assign inv5            = inv5_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser
`timescale 1ns/1ps
module tb_change_dispenser;
  localparam int PULSE_LEN = 4;
  localparam int TIMEOUT   = 1000;
  localparam int INIT_CNT  = 20;
  localparam int CNT_MAX   = 63;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_amount = '0;
  logic       req_ready;
  logic [2:0] eject;
  logic       coin_sensed = 1'b0;
  logic       refill = 1'b0;
  logic [2:0] refill_sel = '0;
  logic       clear = 1'b0;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [7:0] remaining, dispensed_total;
  logic [5:0] inv1, inv2, inv5;

  int n_vec = 0;
  int n_err = 0;
  int m_inv [3];   // model stock: [0]=1 zl, [1]=2 zl, [2]=5 zl

  change_dispenser #(.AMT_W(8), .CNT_W(6), .INIT_CNT(INIT_CNT),
                     .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .eject(eject), .coin_sensed(coin_sensed),
    .refill(refill), .refill_sel(refill_sel), .clear(clear), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .remaining(remaining),
    .dispensed_total(dispensed_total), .inv1(inv1), .inv2(inv2), .inv5(inv5)
  );

  always #5 clk = ~clk;

  function automatic int coin_val(input int idx);
    return (idx == 2) ? 5 : (idx == 1) ? 2 : 1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) m_inv[i] = INIT_CNT;
  endtask

  // Plans the greedy payout on the model stock, then drives and checks one request.
  task automatic run_request(input int amt);
    int  rem, tot, idx, cnt, plen;
    int  coins[$];
    bit  fault;
    rem = amt;
    fault = 1'b0;
    while (rem > 0) begin
      idx = -1;
      if (rem >= 5 && m_inv[2] > 0)      idx = 2;
      else if (rem >= 2 && m_inv[1] > 0) idx = 1;
      else if (m_inv[0] > 0)             idx = 0;
      if (idx < 0) begin
        fault = 1'b1;
        break;
      end
      coins.push_back(idx);
      m_inv[idx]--;
      rem -= coin_val(idx);
    end
    tot = amt - rem;

    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL req_ready_before_req amt=%0d got %b want 1", amt, req_ready);
    end
    req_valid = 1'b1;
    req_amount = 8'(amt);
    @(negedge clk);
    req_valid = 1'b0;

    foreach (coins[i]) begin
      cnt = 0;
      while (eject === 3'b000 && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      n_vec++;
      if (eject !== 3'(1 << coins[i])) begin
        n_err++;
        $display("FAIL eject_coin amt=%0d coin#%0d got %b want %b", amt, i, eject, 3'(1 << coins[i]));
      end
      plen = 0;
      while (eject !== 3'b000 && plen < PULSE_LEN + 5) begin
        @(negedge clk);
        plen++;
      end
      n_vec++;
      if (plen != PULSE_LEN) begin
        n_err++;
        $display("FAIL eject_pulse_len amt=%0d got %0d want %0d", amt, plen, PULSE_LEN);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      coin_sensed = 1'b1;
      @(negedge clk);
      coin_sensed = 1'b0;
    end

    if (fault) begin
      cnt = 0;
      while (error !== 1'b1 && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      n_vec++;
      if ({error, err_code, remaining, dispensed_total} !== {1'b1, 2'b01, 8'(rem), 8'(tot)}) begin
        n_err++;
        $display("FAIL shortfall amt=%0d got err=%b code=%b rem=%0d tot=%0d want 1 01 %0d %0d",
                 amt, error, err_code, remaining, dispensed_total, rem, tot);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_vec++;
      if ({req_ready, error, err_code} !== 4'b1000) begin
        n_err++;
        $display("FAIL clear_to_idle got ready=%b err=%b code=%b want 1 0 00", req_ready, error, err_code);
      end
    end else begin
      cnt = 0;
      while (done !== 1'b1 && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      n_vec++;
      if ({done, remaining, dispensed_total} !== {1'b1, 8'd0, 8'(tot)}) begin
        n_err++;
        $display("FAIL done amt=%0d got done=%b rem=%0d tot=%0d want 1 0 %0d",
                 amt, done, remaining, dispensed_total, tot);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({inv1, inv2, inv5} !== {6'(m_inv[0]), 6'(m_inv[1]), 6'(m_inv[2])}) begin
      n_err++;
      $display("FAIL inventory amt=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
               amt, inv1, inv2, inv5, m_inv[0], m_inv[1], m_inv[2]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req_ready, busy, done, error, err_code, eject, remaining, dispensed_total} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b busy=%b done=%b err=%b code=%b ej=%b rem=%0d tot=%0d",
               req_ready, busy, done, error, err_code, eject, remaining, dispensed_total);
    end
    n_vec++;
    if ({inv1, inv2, inv5} !== {6'd20, 6'd20, 6'd20}) begin
      n_err++;
      $display("FAIL reset_inventory got %0d/%0d/%0d want 20/20/20", inv1, inv2, inv5);
    end
    do_reset();
  endtask

  task automatic test_pay_eight();
    do_reset();
    run_request(8);
    n_vec++;
    if ({inv1, inv2, inv5, dispensed_total} !== {6'd19, 6'd19, 6'd19, 8'd8}) begin
      n_err++;
      $display("FAIL pay_eight got inv %0d/%0d/%0d tot=%0d want 19/19/19 8", inv1, inv2, inv5, dispensed_total);
    end
  endtask

  task automatic test_zero();
    logic [2:0] ej_seen;
    ej_seen = 3'b000;
    do_reset();
    req_valid = 1'b1;
    req_amount = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    ej_seen |= eject;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done_early got %b want 0", done);
    end
    @(negedge clk);
    ej_seen |= eject;
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL zero_done_T+2 got %b want 1", done);
    end
    @(negedge clk);
    ej_seen |= eject;
    n_vec++;
    if ({done, req_ready, ej_seen} !== {1'b0, 1'b1, 3'b000}) begin
      n_err++;
      $display("FAIL zero_after got done=%b ready=%b ejects=%b want 0 1 000", done, req_ready, ej_seen);
    end
    n_vec++;
    if ({inv1, inv2, inv5} !== {6'd20, 6'd20, 6'd20}) begin
      n_err++;
      $display("FAIL zero_inventory got %0d/%0d/%0d want 20/20/20", inv1, inv2, inv5);
    end
  endtask

  task automatic test_shortfall();
    do_reset();
    run_request(100);
    run_request(40);
    run_request(18);
    n_vec++;
    if ({inv1, inv2, inv5} !== {6'd2, 6'd0, 6'd0}) begin
      n_err++;
      $display("FAIL shortfall_setup got %0d/%0d/%0d want 2/0/0", inv1, inv2, inv5);
    end
    run_request(4);
    n_vec++;
    if ({inv1, remaining, dispensed_total} !== {6'd0, 8'd2, 8'd2}) begin
      n_err++;
      $display("FAIL shortfall_hold got inv1=%0d rem=%0d tot=%0d want 0 2 2", inv1, remaining, dispensed_total);
    end
  endtask

  task automatic test_jam();
    int cnt;
    do_reset();
    req_valid = 1'b1;
    req_amount = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (eject === 3'b000 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (eject !== 3'b100) begin
      n_err++;
      $display("FAIL jam_eject got %b want 100", eject);
    end
    cnt = 0;
    while (eject !== 3'b000 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (error !== 1'b1 && cnt < TIMEOUT + 10) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt != TIMEOUT) begin
      n_err++;
      $display("FAIL jam_timeout got %0d cycles want %0d", cnt, TIMEOUT);
    end
    n_vec++;
    if ({error, err_code, remaining, dispensed_total, inv5} !== {1'b1, 2'b10, 8'd5, 8'd0, 6'd20}) begin
      n_err++;
      $display("FAIL jam_state got err=%b code=%b rem=%0d tot=%0d inv5=%0d want 1 10 5 0 20",
               error, err_code, remaining, dispensed_total, inv5);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_vec++;
    if ({req_ready, err_code} !== 3'b100) begin
      n_err++;
      $display("FAIL jam_clear got ready=%b code=%b want 1 00", req_ready, err_code);
    end
  endtask

  task automatic test_reset_mid_eject();
    int cnt;
    do_reset();
    req_valid = 1'b1;
    req_amount = 8'd8;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (eject === 3'b000 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    n_vec++;
    if (eject !== 3'b100) begin
      n_err++;
      $display("FAIL mid_eject_setup got %b want 100", eject);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({eject, req_ready, busy, done, error, err_code, remaining, dispensed_total} !==
        {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL async_reset got ej=%b rdy=%b busy=%b done=%b err=%b code=%b rem=%0d tot=%0d",
               eject, req_ready, busy, done, error, err_code, remaining, dispensed_total);
    end
    n_vec++;
    if ({inv1, inv2, inv5} !== {6'd20, 6'd20, 6'd20}) begin
      n_err++;
      $display("FAIL async_reset_inv got %0d/%0d/%0d want 20/20/20", inv1, inv2, inv5);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) m_inv[i] = INIT_CNT;
  endtask

  task automatic test_refill();
    do_reset();
    req_valid = 1'b1;
    req_amount = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    refill = 1'b1;
    refill_sel = 3'b100;
    repeat (3) @(negedge clk);
    refill = 1'b0;
    n_vec++;
    if (inv5 !== 6'd20) begin
      n_err++;
      $display("FAIL refill_busy got inv5=%0d want 20", inv5);
    end
    while (eject !== 3'b000) @(negedge clk);
    coin_sensed = 1'b1;
    @(negedge clk);
    coin_sensed = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({req_ready, inv5} !== {1'b1, 6'd19}) begin
      n_err++;
      $display("FAIL refill_busy_after got ready=%b inv5=%0d want 1 19", req_ready, inv5);
    end
    refill = 1'b1;
    refill_sel = 3'b001;
    repeat (50) @(negedge clk);
    n_vec++;
    if (inv1 !== 6'(CNT_MAX)) begin
      n_err++;
      $display("FAIL refill_saturate got inv1=%0d want %0d", inv1, CNT_MAX);
    end
    refill_sel = 3'b011;
    repeat (3) @(negedge clk);
    refill_sel = 3'b010;
    @(negedge clk);
    refill = 1'b0;
    n_vec++;
    if ({inv1, inv2, inv5} !== {6'd63, 6'd21, 6'd19}) begin
      n_err++;
      $display("FAIL refill_onehot got %0d/%0d/%0d want 63/21/19", inv1, inv2, inv5);
    end
    m_inv[0] = 63;
    m_inv[1] = 21;
    m_inv[2] = 19;
  endtask

  task automatic test_random();
    int k, idx;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 2);
        k = $urandom_range(1, 8);
        refill = 1'b1;
        refill_sel = 3'(1 << idx);
        repeat (k) @(negedge clk);
        refill = 1'b0;
        m_inv[idx] = (m_inv[idx] + k > CNT_MAX) ? CNT_MAX : m_inv[idx] + k;
      end
      run_request($urandom_range(0, 40));
    end
  endtask

  initial begin
    test_reset();
    test_pay_eight();
    test_zero();
    test_shortfall();
    test_jam();
    test_reset_mid_eject();
    test_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
